// File: rtl/ethernet_info_pkg.sv
// rtl/ethernet_info_pkg.sv - shared TCP descriptor type, flag bits, scheduler states and sequence helpers
package ethernet_info_pkg;

  // Bit positions of the TCP flags inside tcp_packet_info_s.flags
  localparam int FLAG_FIN = 0;
  localparam int FLAG_SYN = 1;
  localparam int FLAG_RST = 2;
  localparam int FLAG_PSH = 3;
  localparam int FLAG_ACK = 4;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [7:0]  flags;
    logic [15:0] window;
    logic [15:0] payload_len;
  } tcp_packet_info_s;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } tx_state_e;

  // Wrap-safe a >= b in 32-bit sequence space
  function automatic logic seq_ge(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    diff = a - b;
    return ~diff[31];
  endfunction

  // A segment consumes sequence space when it carries data, SYN or FIN
  function automatic logic seg_is_tracked(input tcp_packet_info_s info);
    return (info.payload_len != 16'd0) || info.flags[FLAG_SYN] || info.flags[FLAG_FIN];
  endfunction

  // First sequence number after the segment (modulo 2^32)
  function automatic logic [31:0] seg_end_of(input tcp_packet_info_s info);
    return info.seq_num
         + {16'd0, info.payload_len}
         + {31'd0, info.flags[FLAG_SYN]}
         + {31'd0, info.flags[FLAG_FIN]};
  endfunction

endpackage

// File: rtl/tcp_rto_timer.sv
// rtl/tcp_rto_timer.sv - retransmission timeout counter with clear and expire pulse
module tcp_rto_timer
  import ethernet_info_pkg::*;
#(
  parameter int unsigned RTO_CYCLES = 1000000,
  parameter int unsigned TMR_W      = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST_COUNT = TMR_W'(RTO_CYCLES - 1);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  // Expiry is reported once per run; the owner drops run after seeing it
  assign expire = run && !clear && (count_q == LAST_COUNT);

  // Next count: clear wins, otherwise advance while running and not at the limit
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tcp_tx_scheduler.sv
// rtl/tcp_tx_scheduler.sv - arbitrates retransmit / new segment / pure ACK onto the single tcp_sender
module tcp_tx_scheduler
  import ethernet_info_pkg::*;
#(
  parameter int unsigned RTO_CYCLES  = 1000000,
  parameter int unsigned MAX_RETRIES = 4,
  parameter int unsigned TMR_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seg_valid,
  output logic             seg_ready,
  input  tcp_packet_info_s seg_info,
  input  logic             ack_req,
  input  tcp_packet_info_s ack_info,
  input  logic             rx_ack_valid,
  input  logic [31:0]      rx_ack_num,
  output logic             sender_start,
  output tcp_packet_info_s sender_info,
  input  logic             sender_busy,
  output logic             outstanding,
  output logic [2:0]       retry_count,
  output logic             give_up
);

  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRIES);

  tx_state_e        state_q, state_d;
  tcp_packet_info_s info_q, info_d;
  tcp_packet_info_s slot_q, slot_d;
  tcp_packet_info_s ack_buf_q, ack_buf_d;
  logic [31:0]      seg_end_q, seg_end_d;
  logic             ack_pending_q, ack_pending_d;
  logic             outstanding_q, outstanding_d;
  logic             rtx_due_q, rtx_due_d;
  logic [2:0]       retry_q, retry_d;
  logic             give_up_q, give_up_d;
  logic             tracked_send_q, tracked_send_d;
  logic             timer_active_q, timer_active_d;
  logic             ready_q, ready_d;

  logic tmr_clear;
  logic tmr_run;
  logic tmr_expire;
  logic ack_hit;
  logic accept;

  // A covering ACK for the tracked slot, effective at the next edge
  assign ack_hit = rx_ack_valid && outstanding_q && seq_ge(rx_ack_num, seg_end_q);

  // ready_q keeps seg_ready low during reset; busy blocks acceptance because accept implies launch
  assign seg_ready = ready_q && !sender_busy;
  assign accept    = seg_valid && seg_ready;

  // Timer only runs between the end of a tracked send and its expiry
  assign tmr_run = outstanding_q && timer_active_q && !rtx_due_q;

  tcp_rto_timer #(
    .RTO_CYCLES(RTO_CYCLES),
    .TMR_W     (TMR_W)
  ) u_rto_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmr_clear),
    .run   (tmr_run),
    .expire(tmr_expire)
  );

  // Next-state: launch arbitration, sender handshake, timer expiry, ACK retire, ACK coalescing
  always_comb begin
    state_d        = state_q;
    info_d         = info_q;
    slot_d         = slot_q;
    ack_buf_d      = ack_buf_q;
    seg_end_d      = seg_end_q;
    ack_pending_d  = ack_pending_q;
    outstanding_d  = outstanding_q;
    rtx_due_d      = rtx_due_q;
    retry_d        = retry_q;
    give_up_d      = 1'b0;
    tracked_send_d = tracked_send_q;
    timer_active_d = timer_active_q;
    tmr_clear      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!sender_busy) begin
          if (rtx_due_q && !ack_hit) begin
            // Retransmit the stored descriptor unchanged
            info_d         = slot_q;
            retry_d        = retry_q + 3'd1;
            rtx_due_d      = 1'b0;
            tracked_send_d = 1'b1;
            ack_pending_d  = 1'b0;
            state_d        = ST_LAUNCH;
          end else if (accept) begin
            info_d         = seg_info;
            tracked_send_d = seg_is_tracked(seg_info);
            ack_pending_d  = 1'b0;
            state_d        = ST_LAUNCH;
            if (seg_is_tracked(seg_info)) begin
              slot_d        = seg_info;
              seg_end_d     = seg_end_of(seg_info);
              outstanding_d = 1'b1;
              retry_d       = 3'd0;
            end
          end else if (ack_pending_q) begin
            info_d         = ack_buf_q;
            tracked_send_d = 1'b0;
            ack_pending_d  = 1'b0;
            state_d        = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (sender_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!sender_busy) begin
          state_d        = ST_IDLE;
          tracked_send_d = 1'b0;
          // Arm the RTO only if the slot survived this send
          if (tracked_send_q && outstanding_q && !ack_hit) begin
            tmr_clear      = 1'b1;
            timer_active_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Expiry: retransmit later, or give up once the retry budget is spent
    if (tmr_expire && !ack_hit) begin
      timer_active_d = 1'b0;
      if (retry_q == RETRY_LIMIT) begin
        give_up_d     = 1'b1;
        outstanding_d = 1'b0;
        retry_d       = 3'd0;
      end else begin
        rtx_due_d = 1'b1;
      end
    end

    // Covering ACK retires the slot and overrides any pending retransmit
    if (ack_hit) begin
      outstanding_d  = 1'b0;
      rtx_due_d      = 1'b0;
      retry_d        = 3'd0;
      timer_active_d = 1'b0;
    end

    // Latest pure-ACK request wins; one arriving with a launch stays pending
    if (ack_req) begin
      ack_pending_d = 1'b1;
      ack_buf_d     = ack_info;
    end
  end

  // Readiness for a new segment as seen in the next cycle
  always_comb begin
    ready_d = (state_d == ST_IDLE) && !outstanding_d && !rtx_due_d;
  end

  // State registers; reset abandons any send and the tracked slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      info_q         <= '0;
      slot_q         <= '0;
      ack_buf_q      <= '0;
      seg_end_q      <= '0;
      ack_pending_q  <= 1'b0;
      outstanding_q  <= 1'b0;
      rtx_due_q      <= 1'b0;
      retry_q        <= 3'd0;
      give_up_q      <= 1'b0;
      tracked_send_q <= 1'b0;
      timer_active_q <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      info_q         <= info_d;
      slot_q         <= slot_d;
      ack_buf_q      <= ack_buf_d;
      seg_end_q      <= seg_end_d;
      ack_pending_q  <= ack_pending_d;
      outstanding_q  <= outstanding_d;
      rtx_due_q      <= rtx_due_d;
      retry_q        <= retry_d;
      give_up_q      <= give_up_d;
      tracked_send_q <= tracked_send_d;
      timer_active_q <= timer_active_d;
      ready_q        <= ready_d;
    end
  end

  assign sender_start = (state_q == ST_LAUNCH);
  assign sender_info  = info_q;
  assign outstanding  = outstanding_q;
  assign retry_count  = retry_q;
  assign give_up      = give_up_q;

endmodule

// File: doc/tcp_tx_scheduler.md
Name: tcp_tx_scheduler

Overview:
Sequences the single tcp_sender transmit engine between three packet sources: retransmissions, new control/data segments from tcp_brain, and pure ACKs. Holds one outstanding sequence-consuming segment (stop-and-wait), runs its retransmission timer, and retires it on a covering ACK. Sits between tcp_brain and tcp_sender inside tcp_top, replacing the direct sender_start/sender_info connection.

Parameters:
RTO_CYCLES, 1000000, clock cycles from end of a tracked send to retransmission
MAX_RETRIES, 4, retransmissions allowed before give-up
TMR_W, 32, width of the retransmission timer counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
seg_valid  in  1  brain offers a new control/data segment
seg_ready  out  1  segment accepted when seg_valid&&seg_ready
seg_info  in  tcp_packet_info_s  segment descriptor (uses .seq_num, .payload_len, .flags)
ack_req  in  1  pulse: a pure ACK is needed
ack_info  in  tcp_packet_info_s  pure-ACK descriptor, sampled with ack_req
rx_ack_valid  in  1  pulse: validated incoming segment carries ACK flag
rx_ack_num  in  32  acknowledgement number of that segment
sender_start  out  1  one-cycle launch pulse to tcp_sender
sender_info  out  tcp_packet_info_s  descriptor held stable from launch until sender_busy falls
sender_busy  in  1  tcp_sender busy
outstanding  out  1  a tracked segment awaits ACK
retry_count  out  3  retransmissions of current segment
give_up  out  1  one-cycle pulse: MAX_RETRIES exhausted

Behaviour:
- One clock; reset asynchronous, active-low. On reset: all outputs 0, sender_info all-zero, FSM IDLE, timer 0, ack_pending 0, tracked slot empty. Reset mid-send abandons everything; no replay after reset.
- Tracked segment: seg_info with payload_len!=0 or SYN or FIN. seg_end = seq_num + payload_len + SYN + FIN, 32-bit modulo. Untracked seg_info (pure flags, no length) is sent but never stored.
- seg_ready = (state==IDLE) && !outstanding && !rtx_due. Accepting a seg launches it in the same pass (priority below).
- ack_req sets ack_pending and overwrites ack_buf with ack_info; a second ack_req before launch coalesces (latest wins).
- Arbitration in IDLE, highest first: (1) rtx_due -> stored descriptor; (2) seg_valid&&seg_ready -> seg_info; (3) ack_pending -> ack_buf. Any launch clears ack_pending (new/retransmitted segments piggyback ACK); an ack_req in the same cycle as launch stays pending.
- FSM: IDLE -> LAUNCH (sender_info loaded; sender_start=1 exactly one cycle) -> WAIT_BUSY (wait sender_busy=1) -> WAIT_DONE (wait sender_busy=0) -> IDLE. Min 4 cycles per packet. sender_busy already high at IDLE blocks launch.
- Timer: cleared and started when WAIT_DONE exits for a tracked send (original or retransmit); counts while outstanding; rtx_due set when timer==RTO_CYCLES-1; held until launched.
- Retransmit: increments retry_count, re-sends stored descriptor unchanged. If rtx_due arises with retry_count==MAX_RETRIES: no send, give_up pulses 1 cycle, slot cleared, retry_count=0, outstanding=0.
- ACK retire: on rx_ack_valid with outstanding, if (rx_ack_num - seg_end) bit31==0 (wrap-safe >=) -> outstanding=0, timer stopped, rtx_due=0, retry_count=0. Otherwise ignored. Takes effect next cycle; if same cycle as rtx_due launch, ACK wins and no retransmit starts. ACK during an in-flight retransmit retires the slot; current send completes, no timer restart.
- rx_ack_valid with nothing outstanding ignored.

Decomposition:
- tcp_packet_info_s, TCP flag bit constants (FLAG_SYN/FLAG_FIN/FLAG_ACK) and a seq_ge(a,b) function belong in the shared ethernet_info package.
- One sub-module: tcp_rto_timer (count, clear, expire pulse, parameter RTO_CYCLES); rest is one FSM.

Test Plan:
- seg seq=1000 len=100 ACK flag; sender_busy high 10 cycles -> one start pulse, sender_info.seq_num=1000, outstanding=1; rx_ack_num=1100 -> outstanding=0, no retransmit after RTO.
- RTO_CYCLES=50, no ACK -> retransmit start 50 cycles after busy falls, retry_count=1; repeat to 4; 5th expiry -> give_up single pulse, outstanding=0, no 5th retransmit.
- Wrap: seq=32'hFFFF_FFF0 len=0x20 -> seg_end=0x10; rx_ack_num=0x08 ignored, 0x10 retires.
- ack_req x3 while sender busy -> exactly one pure ACK sent carrying third ack_info; seg_valid alongside pending ack -> only the segment sent, ack_pending cleared.
- rtx_due and seg_valid same cycle -> retransmit first, seg_ready=0 throughout; ACK same cycle as expiry -> no retransmit.
- rst_n low during WAIT_DONE -> all outputs 0 immediately; after release no start pulse without new request.
